// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and instruction-field helpers for the decode / operand-fetch stage.
package operand_fetch_stage_pkg;

    // Default datapath geometry.
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_DEF = 31;

    // Opcodes the stage cares about.
    localparam logic [5:0] LW_OP_DEF = 6'h23;
    localparam logic [5:0] OP_RTYPE  = 6'h00;

    // Instruction field bit positions.
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;

    // Raw fields of one instruction; imm overlaps rd/shamt/funct by design.
    typedef struct packed {
        logic [5:0]       op;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    // Slice a 32-bit instruction word into its fields.
    function automatic instr_fields_t decode_instr(input logic [31:0] instr);
        instr_fields_t f;
        f.op    = instr[OP_MSB:OP_LSB];
        f.rs    = instr[RS_MSB:RS_LSB];
        f.rt    = instr[RT_MSB:RT_LSB];
        f.rd    = instr[RD_MSB:RD_LSB];
        f.shamt = instr[SHAMT_MSB:SHAMT_LSB];
        f.funct = instr[FUNCT_MSB:FUNCT_LSB];
        f.imm   = instr[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_load_use_detect.sv
// Load-use hazard compare between the instruction in ID and the load sitting in ID/EX.
module operand_fetch_stage_load_use_detect #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              instr_valid,
    input  logic              stall,
    output logic              hazard
);

    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

    logic dest_live;
    logic src_match;

    // rt is always compared, even for formats that do not read it; an extra
    // bubble is cheaper than decoding which instructions use rt as a source.
    always_comb begin
        dest_live = ex_valid && ex_is_load && (ex_dest != ZERO_SEL);
        src_match = (ex_dest == rs) || (ex_dest == rt);
        hazard    = dest_live && src_match && instr_valid && !stall;
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: register-file selects, write-back bypass,
// load-use bubble insertion and the ID/EX pipeline register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int         DATA_W   = DATA_W_DEF,
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter int         ZERO_REG = ZERO_REG_DEF,
    parameter logic [5:0] LW_OP    = LW_OP_DEF
) (
    input  logic              Clock,
    input  logic              RST,
    input  logic [DATA_W-1:0] Instr,
    input  logic              InstrValid,
    input  logic              Stall,
    input  logic              Flush,
    output logic [ADDR_W-1:0] R1RS,
    output logic [ADDR_W-1:0] R2RS,
    input  logic [DATA_W-1:0] R1ReadData,
    input  logic [DATA_W-1:0] R2ReadData,
    input  logic [ADDR_W-1:0] WRS,
    input  logic [DATA_W-1:0] WD,
    input  logic              SWE,
    output logic              HazardStall,
    output logic              ExValid,
    output logic [DATA_W-1:0] ExOpA,
    output logic [DATA_W-1:0] ExOpB,
    output logic [DATA_W-1:0] ExImm,
    output logic [ADDR_W-1:0] ExDest,
    output logic [ADDR_W-1:0] ExRt,
    output logic [5:0]        ExOpcode,
    output logic [5:0]        ExFunct,
    output logic [4:0]        ExShamt,
    output logic              ExIsLoad
);

    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

    instr_fields_t     f;
    logic [ADDR_W-1:0] rs_sel;
    logic [ADDR_W-1:0] rt_sel;
    logic [ADDR_W-1:0] rd_sel;
    logic [ADDR_W-1:0] dest_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_ext;
    logic              is_load;
    logic              hazard;

    assign f      = decode_instr(Instr[31:0]);
    assign rs_sel = ADDR_W'(f.rs);
    assign rt_sel = ADDR_W'(f.rt);
    assign rd_sel = ADDR_W'(f.rd);

    assign R1RS = rs_sel;
    assign R2RS = rt_sel;

    // Field decode: destination choice, immediate sign extension, load flag.
    always_comb begin
        dest_sel = (f.op == OP_RTYPE) ? rd_sel : rt_sel;
        imm_ext  = {{(DATA_W - IMM_W){f.imm[IMM_W-1]}}, f.imm};
        is_load  = (f.op == LW_OP);
    end

    // The register file commits on the same edge ID/EX captures, so a
    // write-back in flight this cycle must be forwarded into the operands.
    // The hardwired-zero register is never forwarded: it always reads 0.
    always_comb begin
        op_a = R1ReadData;
        op_b = R2ReadData;
        if (SWE && (WRS == rs_sel) && (rs_sel != ZERO_SEL)) begin
            op_a = WD;
        end
        if (SWE && (WRS == rt_sel) && (rt_sel != ZERO_SEL)) begin
            op_b = WD;
        end
    end

    operand_fetch_stage_load_use_detect #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_load_use_detect (
        .ex_valid    (ExValid),
        .ex_is_load  (ExIsLoad),
        .ex_dest     (ExDest),
        .rs          (rs_sel),
        .rt          (rt_sel),
        .instr_valid (InstrValid),
        .stall       (Stall),
        .hazard      (hazard)
    );

    assign HazardStall = hazard;

    // ID/EX register: reset > flush > downstream stall > bubble > capture.
    // The bubble only clears ExValid, which in turn drops the hazard next
    // cycle so the held instruction is captured after exactly one bubble.
    always_ff @(posedge Clock) begin
        if (RST || Flush) begin
            ExValid  <= 1'b0;
            ExOpA    <= '0;
            ExOpB    <= '0;
            ExImm    <= '0;
            ExDest   <= '0;
            ExRt     <= '0;
            ExOpcode <= '0;
            ExFunct  <= '0;
            ExShamt  <= '0;
            ExIsLoad <= 1'b0;
        end else if (Stall) begin
            ExValid  <= ExValid;
        end else if (hazard) begin
            ExValid  <= 1'b0;
        end else begin
            ExValid  <= InstrValid;
            ExOpA    <= op_a;
            ExOpB    <= op_b;
            ExImm    <= imm_ext;
            ExDest   <= dest_sel;
            ExRt     <= rt_sel;
            ExOpcode <= f.op;
            ExFunct  <= f.funct;
            ExShamt  <= f.shamt;
            ExIsLoad <= is_load;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage with a behavioural register file
// and a cycle-level reference model of the ID/EX register.
module tb_operand_fetch_stage;

    logic        Clock = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Instr = '0;
    logic        InstrValid = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [4:0]  R1RS, R2RS;
    logic [31:0] R1ReadData, R2ReadData;
    logic [4:0]  WRS = '0;
    logic [31:0] WD = '0;
    logic        SWE = 1'b0;
    logic        HazardStall;
    logic        ExValid;
    logic [31:0] ExOpA, ExOpB, ExImm;
    logic [4:0]  ExDest, ExRt;
    logic [5:0]  ExOpcode, ExFunct;
    logic [4:0]  ExShamt;
    logic        ExIsLoad;

    int checks = 0;
    int errors = 0;

    // Behavioural register file; entry 31 is hardwired zero.
    logic [31:0] regs [32];
    assign R1ReadData = regs[R1RS];
    assign R2ReadData = regs[R2RS];

    // Reference model of the ID/EX contents.
    logic        e_valid, e_load;
    logic [31:0] e_a, e_b, e_imm;
    logic [4:0]  e_dest, e_rt, e_shamt;
    logic [5:0]  e_op, e_funct;
    logic        hz_exp, hz_obs;

    operand_fetch_stage dut (
        .Clock(Clock), .RST(RST), .Instr(Instr), .InstrValid(InstrValid),
        .Stall(Stall), .Flush(Flush), .R1RS(R1RS), .R2RS(R2RS),
        .R1ReadData(R1ReadData), .R2ReadData(R2ReadData),
        .WRS(WRS), .WD(WD), .SWE(SWE), .HazardStall(HazardStall),
        .ExValid(ExValid), .ExOpA(ExOpA), .ExOpB(ExOpB), .ExImm(ExImm),
        .ExDest(ExDest), .ExRt(ExRt), .ExOpcode(ExOpcode), .ExFunct(ExFunct),
        .ExShamt(ExShamt), .ExIsLoad(ExIsLoad)
    );

    always #5 Clock = ~Clock;

    // Advance one clock: predict the hazard and the next ID/EX contents from
    // the instruction-set rules, then commit model and register file.
    task automatic step();
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b;
        #1;
        hz_obs = HazardStall;
        op = Instr[31:26];
        rs = Instr[25:21];
        rt = Instr[20:16];
        rd = Instr[15:11];
        hz_exp = e_valid && e_load && e_dest != 5'd31 && (e_dest == rs || e_dest == rt)
                 && InstrValid && !Stall;
        a = (SWE && WRS == rs && rs != 5'd31) ? WD : regs[rs];
        b = (SWE && WRS == rt && rt != 5'd31) ? WD : regs[rt];
        @(posedge Clock);
        #1;
        if (RST || Flush) begin
            e_valid = 0; e_load = 0; e_a = 0; e_b = 0; e_imm = 0;
            e_dest = 0; e_rt = 0; e_shamt = 0; e_op = 0; e_funct = 0;
        end else if (Stall) begin
            // contents frozen
        end else if (hz_exp) begin
            e_valid = 0;
        end else begin
            e_valid = InstrValid;
            e_a     = a;
            e_b     = b;
            e_imm   = $signed(Instr[15:0]);
            e_dest  = (op == 6'd0) ? rd : rt;
            e_rt    = rt;
            e_op    = op;
            e_funct = Instr[5:0];
            e_shamt = Instr[10:6];
            e_load  = (op == 6'h23);
        end
        if (SWE && WRS != 5'd31) regs[WRS] = WD;
    endtask

    task automatic idle_inputs();
        RST = 0; Stall = 0; Flush = 0; SWE = 0; InstrValid = 1;
    endtask

    task automatic test_reset();
        RST = 1;
        for (int i = 0; i < 2; i++) begin
            Instr = $urandom; InstrValid = 1; SWE = $urandom_range(0, 1);
            WRS = $urandom; WD = $urandom;
            step();
        end
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ExValid); end
        checks++; if ({ExOpA, ExOpB, ExImm} !== 96'd0) begin errors++; $display("FAIL reset_ops got %h %h %h want 0", ExOpA, ExOpB, ExImm); end
        checks++; if ({ExDest, ExRt, ExOpcode, ExFunct, ExShamt, ExIsLoad} !== 28'd0) begin
            errors++; $display("FAIL reset_fields got %h %h %h %h %h %b want 0", ExDest, ExRt, ExOpcode, ExFunct, ExShamt, ExIsLoad);
        end
        #1;
        checks++; if (HazardStall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", HazardStall); end
    endtask

    task automatic test_rtype();
        idle_inputs();
        regs[1] = 32'd5; regs[2] = 32'd7;
        Instr = 32'h0022_1820;
        step();
        checks++; if (ExOpA !== 32'd5 || ExOpB !== 32'd7) begin errors++; $display("FAIL rtype_ops got %0d %0d want 5 7", ExOpA, ExOpB); end
        checks++; if (ExDest !== 5'd3 || ExValid !== 1'b1) begin errors++; $display("FAIL rtype_dest got %0d v%0b want 3 v1", ExDest, ExValid); end
        checks++; if (ExFunct !== 6'h20 || ExOpcode !== 6'h00 || ExRt !== 5'd2) begin
            errors++; $display("FAIL rtype_fields got f%h o%h rt%0d want f20 o00 rt2", ExFunct, ExOpcode, ExRt);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        regs[1] = 32'd5;
        Instr = 32'h0022_1820; SWE = 1; WRS = 5'd1; WD = 32'h0000_DEAD;
        step();
        checks++; if (ExOpA !== 32'h0000_DEAD) begin errors++; $display("FAIL bypass_a got %h want 0000dead", ExOpA); end
        checks++; if (ExOpB !== e_b) begin errors++; $display("FAIL bypass_b got %h want %h", ExOpB, e_b); end
        Instr = 32'h03E2_1820; SWE = 1; WRS = 5'd31; WD = 32'h1234_5678;
        step();
        checks++; if (ExOpA !== 32'd0) begin errors++; $display("FAIL bypass_zero got %h want 0", ExOpA); end
        SWE = 0;
    endtask

    task automatic test_load_use();
        idle_inputs();
        Instr = 32'h8C24_0000;              // lw $4,0($1)
        step();
        checks++; if (ExIsLoad !== 1'b1 || ExDest !== 5'd4) begin errors++; $display("FAIL lu_load got l%0b d%0d want l1 d4", ExIsLoad, ExDest); end
        Instr = 32'h0082_2820;              // add $5,$4,$2
        step();
        checks++; if (hz_obs !== 1'b1) begin errors++; $display("FAIL lu_hazard got %0b want 1", hz_obs); end
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b want 0", ExValid); end
        step();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL lu_hazard_drop got %0b want 0", hz_obs); end
        checks++; if (ExValid !== 1'b1 || ExDest !== 5'd5) begin errors++; $display("FAIL lu_capture got v%0b d%0d want v1 d5", ExValid, ExDest); end
    endtask

    task automatic test_immediate();
        idle_inputs();
        Instr = 32'h2026_FFFC;              // addi $6,$1,-4
        step();
        checks++; if (ExImm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_ext got %h want fffffffc", ExImm); end
        checks++; if (ExDest !== 5'd6) begin errors++; $display("FAIL imm_dest got %0d want 6", ExDest); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] a0, imm0;
        logic [4:0]  d0;
        idle_inputs();
        Instr = 32'h0022_1820;
        step();
        a0 = ExOpA; imm0 = ExImm; d0 = ExDest;
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            Instr = $urandom; SWE = 1; WRS = $urandom; WD = $urandom;
            step();
            checks++; if (ExOpA !== a0 || ExImm !== imm0 || ExDest !== d0 || ExValid !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc%0d got %h %h %0d v%0b want %h %h %0d v1", i, ExOpA, ExImm, ExDest, ExValid, a0, imm0, d0);
            end
        end
        SWE = 0; Flush = 1;
        step();
        checks++; if (ExValid !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", ExValid); end
        Flush = 0; Stall = 0;
    endtask

    task automatic test_random();
        logic [4:0] pick [6];
        logic [5:0] ops [4];
        pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31, 5'd7};
        ops  = '{6'h00, 6'h23, 6'h08, 6'h23};
        for (int n = 0; n < 400; n++) begin
            RST        = ($urandom_range(0, 60) == 0);
            Flush      = ($urandom_range(0, 15) == 0);
            Stall      = ($urandom_range(0, 7) == 0);
            InstrValid = ($urandom_range(0, 9) != 0);
            SWE        = $urandom_range(0, 1);
            WRS        = pick[$urandom_range(0, 5)];
            WD         = $urandom;
            if (!hz_exp || $urandom_range(0, 3) == 0) begin
                Instr = $urandom;
                Instr[31:26] = ops[$urandom_range(0, 3)];
                Instr[25:21] = pick[$urandom_range(0, 5)];
                Instr[20:16] = pick[$urandom_range(0, 5)];
                Instr[15:11] = pick[$urandom_range(0, 5)];
            end
            #1;
            checks++; if (R1RS !== Instr[25:21] || R2RS !== Instr[20:16]) begin
                errors++; $display("FAIL rnd_sel n%0d got %0d %0d want %0d %0d", n, R1RS, R2RS, Instr[25:21], Instr[20:16]);
            end
            step();
            checks++; if (hz_obs !== hz_exp) begin errors++; $display("FAIL rnd_hazard n%0d got %0b want %0b", n, hz_obs, hz_exp); end
            checks++; if (ExValid !== e_valid) begin errors++; $display("FAIL rnd_valid n%0d got %0b want %0b", n, ExValid, e_valid); end
            if (e_valid) begin
                checks++; if (ExOpA !== e_a || ExOpB !== e_b) begin
                    errors++; $display("FAIL rnd_ops n%0d got %h %h want %h %h", n, ExOpA, ExOpB, e_a, e_b);
                end
                checks++; if (ExImm !== e_imm || ExDest !== e_dest || ExRt !== e_rt || ExIsLoad !== e_load) begin
                    errors++; $display("FAIL rnd_fields n%0d got %h %0d %0d %0b want %h %0d %0d %0b", n, ExImm, ExDest, ExRt, ExIsLoad, e_imm, e_dest, e_rt, e_load);
                end
                checks++; if (ExOpcode !== e_op || ExFunct !== e_funct || ExShamt !== e_shamt) begin
                    errors++; $display("FAIL rnd_ctl n%0d got %h %h %0d want %h %h %0d", n, ExOpcode, ExFunct, ExShamt, e_op, e_funct, e_shamt);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 31) ? 32'd0 : $urandom;
        e_valid = 0; e_load = 0; e_a = 0; e_b = 0; e_imm = 0;
        e_dest = 0; e_rt = 0; e_shamt = 0; e_op = 0; e_funct = 0;
        hz_exp = 0; hz_obs = 0;
        @(negedge Clock);
        test_reset();
        test_rtype();
        test_bypass();
        test_load_use();
        test_immediate();
        test_stall_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode/operand-fetch pipeline stage sitting directly downstream of the 32x32 register file. Slices the incoming instruction, drives the two read selects into the register file, and captures operands, immediate and control fields into the ID/EX pipeline register. Bypasses a same-cycle write-back into the captured operands. Detects load-use hazards and inserts one bubble while holding the fetch stage.

## Interface
Parameters:
- DATA_W, 32, operand and instruction width
- ADDR_W, 5, register select width
- ZERO_REG, 31, hardwired-zero register index; never bypassed, never a hazard source
- LW_OP, 6'h23, opcode marking a load

Ports:
- Clock  in  1  single clock; all state updates on its rising edge
- RST  in  1  synchronous, active-high reset
- Instr  in  DATA_W  instruction from fetch
- InstrValid  in  1  Instr is a real instruction
- Stall  in  1  downstream hold; ID/EX register keeps its contents
- Flush  in  1  branch/jump squash; next ID/EX contents invalid
- R1RS, R2RS  out  ADDR_W  read selects to register file (combinational, Instr[25:21], Instr[20:16])
- R1ReadData, R2ReadData  in  DATA_W  read data from register file (combinational)
- WRS  in  ADDR_W, WD  in  DATA_W, SWE  in  1  write-back port, same signals driving the register file
- HazardStall  out  1  hold fetch/PC this cycle (combinational)
- ExValid  out  1; ExOpA, ExOpB  out  DATA_W; ExImm  out  DATA_W; ExDest  out  ADDR_W; ExRt  out  ADDR_W; ExOpcode  out  6; ExFunct  out  6; ExShamt  out  5; ExIsLoad  out  1

## Operation
- Fields: op=Instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- Dest: op==0 -> rd, else rt. ExImm = sign-extend(imm) to DATA_W.
- Bypass: opA = WD if SWE && WRS==rs && rs!=ZERO_REG, else R1ReadData; opB likewise with rt/R2ReadData. Needed because register file commits on the same edge that ID/EX captures.
- Hazard: HazardStall = ExValid && ExIsLoad && ExDest!=ZERO_REG && (ExDest==rs || ExDest==rt) && InstrValid && !Stall. Comparison against rt is always made (conservative).
- ID/EX update priority per edge: RST > Flush > Stall > HazardStall > load.
  - RST: every Ex output to 0.
  - Flush: ExValid<=0, other fields don't-care (implementation clears to 0).
  - Stall: all Ex registers hold.
  - HazardStall: ExValid<=0 (bubble); fetch holds Instr, so the same instruction loads next cycle.
  - Load: ExValid<=InstrValid, all fields from current Instr, operands after bypass.
- Bubble lasts exactly one cycle: after it ExValid=0, so HazardStall drops.

## Timing
- Select-to-capture latency: one cycle; Ex outputs valid the cycle after Instr is presented.
- R1RS/R2RS, HazardStall combinational; no other combinational path input->output.
- Reset: all outputs registered 0 the cycle after RST sampled high; HazardStall 0 (ExValid=0).
- Flush and HazardStall same cycle: Flush wins, fetch still sees HazardStall (harmless, fetch is redirected).
- Stall asserted: HazardStall forced 0; ID/EX and its hazard state frozen.
- Write-back to ZERO_REG: no bypass; operand taken from register file (reads 0).
- RST mid-bubble: bubble abandoned, state cleared.

## Structure
- Shared package: field bit positions, LW_OP and R-type opcode constants, ZERO_REG, DATA_W/ADDR_W.
- One sub-module natural: load_use_detect (combinational hazard compare); bypass muxes and ID/EX register stay in the top.

## Test plan
- Reset: RST=1 two cycles with random Instr -> all Ex outputs 0, HazardStall 0.
- R-type: Instr=add $3,$1,$2 (0x00221820), regfile returns 5/7, SWE=0 -> next cycle ExOpA=5, ExOpB=7, ExDest=3, ExValid=1.
- Bypass: same Instr with SWE=1, WRS=1, WD=0xDEAD -> ExOpA=0xDEAD. Repeat with WRS=31 and rs=31 -> ExOpA=R1ReadData (0).
- Load-use: lw $4,0($1) then add $5,$4,$2 -> HazardStall=1 one cycle, one ExValid=0 bubble, then add captured with ExDest=5.
- Immediate: addi with imm=0xFFFC -> ExImm=0xFFFFFFFC, ExDest=rt.
- Stall/Flush: Stall=1 three cycles -> Ex outputs frozen; Flush=1 with Stall=1 -> ExValid=0 next cycle.
